matrix_coef_sequencer: RTL and testbench
========================================

// Module: matrix_coef_sequencer
// PURPOSE
//  Loads and schedules coefficient writes into the 3x3 matrix-multiply core's coefficient bank.
//  Software stages 8 coefficients in shadow registers via the system bus, then commits them.
//  A commit snapshots all 8 values and bursts them onto the core's 53-bit write word, one per cycle.
//  Arbitrates that write word between the commit burst and a single-write adaptation requester (adp_*).
// PARAMETERS
//  N_COEF       8        coefficients per burst; also the shadow depth (fixed at 8 for this core)
//  ADDR_BASE    20'h0    core address of coefficient 0
//  ADDR_STRIDE  20'd4    core address step between coefficients
//  REG_BASE     20'h0    bus base of this block's 64-byte register window; matches on addr[19:6]
// PORTS
//  system1000      in   1   clock
//  system1000_rst  in   1   synchronous reset, active high
//  sys_addr        in   20  bus address
//  sys_wdata       in   32  bus write data
//  sys_wen         in   1   bus write strobe
//  sys_ren         in   1   bus read strobe
//  sys_rdata       out  32  bus read data, valid with sys_ack
//  sys_ack         out  1   bus acknowledge
//  adp_valid       in   1   adaptation write request
//  adp_addr        in   20  adaptation target address
//  adp_data        in   32  adaptation data
//  adp_ready       out  1   adaptation request accepted this cycle when adp_valid=1
//  core_hold       in   1   core freeze: no new write words are issued while high
//  coef_wr         out  53  {valid[52], addr[51:32], data[31:0]}: core write word
//  burst_done      out  1   1-cycle pulse with the last word of a burst
// BEHAVIOUR
//  Reset:
//   - All outputs are 0; shadow and stage banks are 0; state=IDLE, idx=0, pending=0.
//   - A reset during a burst abandons it; no further words are issued.
//  Register map (offset = sys_addr[5:0]; block is selected when sys_addr[19:6]==REG_BASE[19:6]):
//   - 0x00..0x1C: shadow[0..7], read/write.
//   - 0x20 CTRL: write bit0=1 commits; reads return 0.
//   - 0x24 STATUS (read-only): bit0=busy (state==BURST), bit1=pending, bits[6:4]=idx.
//   - Other offsets read as 0; writes to them are ignored.
//  Bus timing:
//   - sys_ack=1 exactly one cycle after a selected wen or ren; sys_rdata is registered with it.
//   - Shadow writes are always accepted, including mid-burst; they affect only the next commit.
//  State machine, IDLE/BURST:
//   - IDLE + commit, or IDLE + pending: at that edge, stage<=shadow, idx<=0, pending<=0, state<=BURST.
//   - BURST + core_hold=0: at each edge, coef_wr<={1, ADDR_BASE+idx*ADDR_STRIDE, stage[idx]}, idx<=idx+1.
//   - BURST + core_hold=1: coef_wr.valid<=0 and idx holds.
//   - Last word (idx==N_COEF-1), without pending: burst_done<=1 and state<=IDLE.
//   - Last word with pending=1: burst_done<=1, stage<=shadow, idx<=0, pending<=0, state stays BURST. No gap cycle.
//   - Commit while BURST: pending<=1. A further commit while pending=1 is absorbed (one pending only).
//  Arbitration:
//   - adp_ready = (state==IDLE) & ~pending & ~core_hold; combinational.
//   - An accepted adp write at edge j drives coef_wr<={1, adp_addr, adp_data} at edge j.
//   - The burst has absolute priority; adp waits at most N_COEF+1 unheld cycles per burst.
//   - Commit and adp in the same IDLE cycle: the adp word issues first, and the burst starts the next edge.
//  Timing and width rules:
//   - coef_wr.valid is high for exactly one cycle per word; otherwise coef_wr=0.
//   - Commit sampled at edge k with no hold: words 0..7 at edges k+1..k+8; burst_done at edge k+8.
//   - Address arithmetic is modulo 2^20; wrap is allowed and not flagged.
// TESTING
//  1. Write shadow[i]=32'h100+i, commit, no hold -> 8 consecutive words, addr 0,4,..,0x1C, data 0x100..0x107; burst_done with word 7.
//  2. Commit, then rewrite shadow[3]=0xDEAD mid-burst -> burst still emits 0x103; a second commit emits 0xDEAD.
//  3. Commit twice during a burst -> exactly one back-to-back restart, 16 words total, no gap; STATUS.pending clears at the restart.
//  4. Raise core_hold for 3 cycles at idx=4 -> valid low for 3 cycles; word 4 (0x104) follows; 8 words total.
//  5. adp_valid held during a burst -> adp_ready=0 until IDLE; the adp word appears one edge after acceptance; in IDLE it is accepted the same cycle as a commit and issues first.
//  6. Assert system1000_rst at idx=5 -> coef_wr=0, STATUS=0, shadow reads 0; a new commit after reset emits zeros.

Source files
------------

// File: rtl/matrix_coef_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : matrix_coef_sequencer
// Function : Shadow/stage coefficient bank that bursts into the 3x3 matrix
//            core write port, shared with a single-write adaptation requester.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_coef_sequencer #(
    parameter int          N_COEF      = 8,
    parameter logic [19:0] ADDR_BASE   = 20'h0,
    parameter logic [19:0] ADDR_STRIDE = 20'd4,
    parameter logic [19:0] REG_BASE    = 20'h0
) (
    input  logic        system1000,
    input  logic        system1000_rst,
    input  logic [19:0] sys_addr,
    input  logic [31:0] sys_wdata,
    input  logic        sys_wen,
    input  logic        sys_ren,
    output logic [31:0] sys_rdata,
    output logic        sys_ack,
    input  logic        adp_valid,
    input  logic [19:0] adp_addr,
    input  logic [31:0] adp_data,
    output logic        adp_ready,
    input  logic        core_hold,
    output logic [52:0] coef_wr,
    output logic        burst_done
);
    localparam logic [2:0] c_LAST_IDX   = 3'(N_COEF - 1);
    localparam logic [5:0] c_OFS_CTRL   = 6'h20;
    localparam logic [5:0] c_OFS_STATUS = 6'h24;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic        r_pending, w_pending_nxt;
    logic        w_load_stage;
    logic [52:0] r_coef_wr, w_coef_wr_nxt;
    logic        r_burst_done, w_burst_done_nxt;
    logic [31:0] r_shadow [N_COEF];
    logic [31:0] r_stage  [N_COEF];
    logic        r_sys_ack;
    logic [31:0] r_sys_rdata, w_rdata;
    logic        w_sel, w_wr, w_rd, w_commit, w_shadow_hit, w_adp_ready;
    logic [19:0] w_word_addr;
    logic [31:0] w_status;

    always_comb begin
        w_sel        = (sys_addr[19:6] == REG_BASE[19:6]);
        w_wr         = w_sel & sys_wen;
        w_rd         = w_sel & sys_ren;
        w_shadow_hit = ~sys_addr[5] & (sys_addr[1:0] == 2'b00);
        w_commit     = w_wr & (sys_addr[5:0] == c_OFS_CTRL) & sys_wdata[0];
        // Gated by reset so every output reads 0 while reset is held.
        w_adp_ready  = (r_state == ST_IDLE) & ~r_pending & ~core_hold & ~system1000_rst;
        w_word_addr  = ADDR_BASE + 20'(r_idx) * ADDR_STRIDE;
        w_status     = {25'd0, r_idx, 2'b00, r_pending, r_state == ST_BURST};
        w_rdata      = '0;
        if (w_shadow_hit)
            w_rdata = r_shadow[sys_addr[4:2]];
        else if (sys_addr[5:0] == c_OFS_STATUS)
            w_rdata = w_status;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_pending_nxt    = r_pending;
        w_load_stage     = 1'b0;
        w_coef_wr_nxt    = '0;
        w_burst_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_adp_ready && adp_valid)
                    w_coef_wr_nxt = {1'b1, adp_addr, adp_data};
                if (w_commit || r_pending) begin
                    w_load_stage  = 1'b1;
                    w_idx_nxt     = '0;
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_commit)
                    w_pending_nxt = 1'b1;
                if (!core_hold) begin
                    w_coef_wr_nxt = {1'b1, w_word_addr, r_stage[r_idx]};
                    if (r_idx == c_LAST_IDX) begin
                        w_burst_done_nxt = 1'b1;
                        w_idx_nxt        = '0;
                        // A pending commit restarts back-to-back; a commit landing
                        // on this same edge is absorbed into that restart.
                        if (r_pending) begin
                            w_load_stage  = 1'b1;
                            w_pending_nxt = 1'b0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_pending    <= 1'b0;
            r_coef_wr    <= '0;
            r_burst_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_pending    <= w_pending_nxt;
            r_coef_wr    <= w_coef_wr_nxt;
            r_burst_done <= w_burst_done_nxt;
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            for (int i = 0; i < N_COEF; i++) begin
                r_shadow[i] <= '0;
                r_stage[i]  <= '0;
            end
            r_sys_ack   <= 1'b0;
            r_sys_rdata <= '0;
        end else begin
            if (w_load_stage)
                r_stage <= r_shadow;
            if (w_wr && w_shadow_hit)
                r_shadow[sys_addr[4:2]] <= sys_wdata;
            r_sys_ack   <= w_wr | w_rd;
            r_sys_rdata <= w_rd ? w_rdata : '0;
        end
    end

    assign adp_ready  = w_adp_ready;
    assign coef_wr    = r_coef_wr;
    assign burst_done = r_burst_done;
    assign sys_ack    = r_sys_ack;
    assign sys_rdata  = r_sys_rdata;

endmodule
`default_nettype wire

// File: tb/tb_matrix_coef_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_coef_sequencer
// Function : Directed and random stimulus for matrix_coef_sequencer against a
//            queue-based reference model of the coefficient burst behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_coef_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen, sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_ack;
    logic        adp_valid;
    logic [19:0] adp_addr;
    logic [31:0] adp_data;
    logic        adp_ready;
    logic        core_hold;
    logic [52:0] coef_wr;
    logic        burst_done;

    always #5 clk = ~clk;

    matrix_coef_sequencer dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .sys_addr       (sys_addr),
        .sys_wdata      (sys_wdata),
        .sys_wen        (sys_wen),
        .sys_ren        (sys_ren),
        .sys_rdata      (sys_rdata),
        .sys_ack        (sys_ack),
        .adp_valid      (adp_valid),
        .adp_addr       (adp_addr),
        .adp_data       (adp_data),
        .adp_ready      (adp_ready),
        .core_hold      (core_hold),
        .coef_wr        (coef_wr),
        .burst_done     (burst_done)
    );

    int checks      = 0;
    int errors      = 0;
    int valid_words = 0;

    // Reference model: remaining burst words are a queue snapshotted at burst start.
    logic [31:0] m_shadow [8];
    logic [52:0] m_q [$];
    logic        m_pend;

    function automatic void m_fill();
        m_q.delete();
        for (int i = 0; i < 8; i++)
            m_q.push_back({1'b1, 20'(i * 4), m_shadow[i]});
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] ofs);
        if (ofs < 6'h20 && ofs[1:0] == 2'b00)
            return m_shadow[ofs[4:2]];
        if (ofs == 6'h24)
            return {25'd0, 3'((8 - m_q.size()) % 8), 2'b00, m_pend, m_q.size() != 0};
        return '0;
    endfunction

    task automatic check(input string tag, input logic [52:0] obs, input logic [52:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [52:0] e_wr;
        logic        e_done, e_ack, e_ready, sel, commit, old_pend;
        logic [31:0] e_rd;
        e_wr = '0; e_done = 1'b0; e_ack = 1'b0; e_ready = 1'b0; e_rd = '0;
        sel = (sys_addr[19:6] == 14'd0);
        if (rst) begin
            for (int i = 0; i < 8; i++) m_shadow[i] = '0;
            m_q.delete();
            m_pend = 1'b0;
        end else begin
            commit = sel && sys_wen && sys_addr[5:0] == 6'h20 && sys_wdata[0];
            e_ack  = sel && (sys_wen || sys_ren);
            if (sel && sys_ren) e_rd = m_read(sys_addr[5:0]);
            if (m_q.size() != 0) begin
                old_pend = m_pend;
                if (commit) m_pend = 1'b1;
                if (!core_hold) begin
                    e_wr = m_q.pop_front();
                    if (m_q.size() == 0) begin
                        e_done = 1'b1;
                        if (old_pend) begin
                            m_fill();
                            m_pend = 1'b0;
                        end
                    end
                end
            end else begin
                e_ready = !m_pend && !core_hold;
                if (e_ready && adp_valid) e_wr = {1'b1, adp_addr, adp_data};
                if (commit || m_pend) begin
                    m_fill();
                    m_pend = 1'b0;
                end
            end
            if (sel && sys_wen && sys_addr[5:0] < 6'h20 && sys_addr[1:0] == 2'b00)
                m_shadow[sys_addr[4:2]] = sys_wdata;
        end
        #1;
        check("adp_ready", 53'(adp_ready), 53'(e_ready));
        @(posedge clk);
        #1;
        check("coef_wr", coef_wr, e_wr);
        check("burst_done", 53'(burst_done), 53'(e_done));
        check("sys_ack", 53'(sys_ack), 53'(e_ack));
        check("sys_rdata", 53'(sys_rdata), 53'(e_rd));
        if (coef_wr[52]) valid_words++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [19:0] a, input logic [31:0] d);
        sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
        step();
        sys_wen = 1'b0; sys_addr = '0; sys_wdata = '0;
    endtask

    task automatic rd(input logic [19:0] a);
        sys_addr = a; sys_ren = 1'b1;
        step();
        sys_ren = 1'b0; sys_addr = '0;
    endtask

    initial begin
        int          r;
        logic [5:0]  ofs;
        rst = 1'b1; sys_addr = '0; sys_wdata = '0; sys_wen = 1'b0; sys_ren = 1'b0;
        adp_valid = 1'b0; adp_addr = '0; adp_data = '0; core_hold = 1'b0;
        idle(2);
        rst = 1'b0;
        rd(20'h24);

        // Plain burst of 0x100..0x107
        for (int i = 0; i < 8; i++) wr(20'(i * 4), 32'h100 + 32'(i));
        valid_words = 0;
        wr(20'h20, 32'h1);
        idle(10);
        check("burst1_words", 53'(valid_words), 53'd8);

        // Shadow rewrite mid-burst affects only the next commit
        wr(20'h20, 32'h1);
        idle(2);
        wr(20'h0C, 32'hDEAD);
        idle(8);
        wr(20'h20, 32'h1);
        idle(10);
        rd(20'h0C);

        // Two commits during a burst collapse into one restart
        valid_words = 0;
        wr(20'h20, 32'h1);
        idle(2);
        wr(20'h20, 32'h1);
        idle(1);
        rd(20'h24);
        wr(20'h20, 32'h1);
        for (int i = 0; i < 10; i++) rd(20'h24);
        idle(10);
        check("restart_words", 53'(valid_words), 53'd16);

        // Three-cycle hold at idx 4
        valid_words = 0;
        wr(20'h20, 32'h1);
        idle(4);
        core_hold = 1'b1;
        idle(3);
        core_hold = 1'b0;
        idle(8);
        check("hold_words", 53'(valid_words), 53'd8);

        // Adaptation request across a burst, then colliding with a commit
        adp_valid = 1'b1; adp_addr = 20'hABCDE; adp_data = 32'h5A5A_1234;
        wr(20'h20, 32'h1);
        idle(12);
        adp_addr = 20'h12345; adp_data = 32'hCAFE_F00D;
        wr(20'h20, 32'h1);
        adp_valid = 1'b0;
        idle(10);

        // Reset in the middle of a burst
        wr(20'h20, 32'h1);
        idle(5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd(20'h24);
        rd(20'h00);
        wr(20'h20, 32'h1);
        idle(10);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            r = int'($urandom_range(0, 99));
            case ($urandom_range(0, 5))
                0, 1:    ofs = {1'b0, 3'($urandom), 2'b00};
                2:       ofs = 6'h20;
                3:       ofs = 6'h24;
                default: ofs = 6'($urandom);
            endcase
            sys_addr  = ($urandom_range(0, 9) == 0) ?
                        {14'($urandom_range(1, 16383)), ofs} : {14'd0, ofs};
            sys_wen   = (r < 25);
            sys_ren   = (r >= 25 && r < 50);
            sys_wdata = $urandom;
            core_hold = ($urandom_range(0, 9) == 0);
            adp_valid = ($urandom_range(0, 3) == 0);
            adp_addr  = 20'($urandom);
            adp_data  = $urandom;
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; sys_wen = 1'b0; sys_ren = 1'b0; adp_valid = 1'b0; core_hold = 1'b0;
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
